// File: rtl/transmitter_shift.sv
// Parallel-load, serial-out transmitter with a bit counter, busy flag and frame-done pulse.
// Optional even-parity trailer bit is compiled in with `define TRANSMITTER_PARITY_EN.
module transmitter_shift #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] qin,
  input  logic             serialin,
  output logic             serialout,
  output logic [WIDTH-1:0] qout,
  output logic             co,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
`ifdef TRANSMITTER_PARITY_EN
  localparam logic [1:0] StParity = 2'd2;
`endif

  logic [WIDTH-1:0] r_qout, w_qout_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [1:0]       r_state, w_state_d;
  logic             r_co, w_co_d;
`ifdef TRANSMITTER_PARITY_EN
  logic             r_par, w_par_d;
`endif

  logic [WIDTH-1:0] w_shifted;
  logic             w_last_bit;
  logic             w_data_bit;

  // The vacated end is refilled from serialin on every shift.
  assign w_shifted  = MSB_FIRST ? {r_qout[WIDTH-2:0], serialin}
                                : {serialin, r_qout[WIDTH-1:1]};
  assign w_last_bit = (r_cnt == CntW'(WIDTH - 1));
  assign w_data_bit = MSB_FIRST ? r_qout[WIDTH-1] : r_qout[0];

  always_comb begin
    w_qout_d  = r_qout;
    w_cnt_d   = r_cnt;
    w_state_d = r_state;
    w_co_d    = 1'b0;
`ifdef TRANSMITTER_PARITY_EN
    w_par_d   = r_par;
`endif
    if (load) begin
      // Load aborts any frame in progress without a done pulse.
      w_qout_d  = qin;
      w_cnt_d   = '0;
      w_state_d = StShift;
`ifdef TRANSMITTER_PARITY_EN
      w_par_d   = ^qin;
`endif
    end else if (enable) begin
      case (r_state)
        StShift: begin
          w_qout_d = w_shifted;
          w_cnt_d  = r_cnt + CntW'(1);
          if (w_last_bit) begin
`ifdef TRANSMITTER_PARITY_EN
            w_state_d = StParity;
`else
            w_state_d = StIdle;
            w_co_d    = 1'b1;
`endif
          end
        end
`ifdef TRANSMITTER_PARITY_EN
        StParity: begin
          w_state_d = StIdle;
          w_co_d    = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_qout  <= '0;
      r_cnt   <= '0;
      r_state <= StIdle;
      r_co    <= 1'b0;
    end else begin
      r_qout  <= w_qout_d;
      r_cnt   <= w_cnt_d;
      r_state <= w_state_d;
      r_co    <= w_co_d;
    end
  end

`ifdef TRANSMITTER_PARITY_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_par <= 1'b0;
    end else begin
      r_par <= w_par_d;
    end
  end

  assign serialout = (r_state == StParity) ? r_par : w_data_bit;
`else
  assign serialout = w_data_bit;
`endif

  assign qout = r_qout;
  assign co   = r_co;
  assign busy = (r_state != StIdle);

endmodule

// File: doc/transmitter_shift.md
# transmitter_shift

Parametrised parallel-load, serial-out transmitter for the latches/flip-flops lab designs. A `WIDTH`-bit shift register is loaded in parallel, then shifted out one bit per enabled clock, MSB- or LSB-first, while `serialin` refills the vacated end. A bit counter sequences the frame, drives a `busy` flag and a one-cycle `co` frame-done pulse, and optionally appends an even-parity bit.

## Interface
- `WIDTH`, 8: word width in bits; legal range is `WIDTH >= 2`.
- `MSB_FIRST`, 1: 1 shifts `qout[WIDTH-1]` out first; 0 shifts `qout[0]` out first.
- `clock` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset. Low clears all state immediately.
- `load` input 1: synchronous parallel load / frame start. Has priority over `enable`.
- `enable` input 1: shift advance; one bit per rising edge while high.
- `qin` input WIDTH: parallel data, sampled when `load`=1.
- `serialin` input 1: bit inserted at the non-output end on each shift.
- `serialout` output 1: current outgoing bit.
- `qout` output WIDTH: shift-register contents.
- `co` output 1: registered frame-complete pulse, one cycle wide.
- `busy` output 1: high while a frame is in progress.

## Operation
- States: IDLE, SHIFT, PARITY. PARITY exists only with `TRANSMITTER_PARITY_EN`.
- Bit counter width is `$clog2(WIDTH+1)`.
- Reset (`reset`=0), asynchronous:
  - `qout`=0, `co`=0, `busy`=0, counter=0, parity register=0, state=IDLE.
  - `serialout` follows the selected end of `qout`, so it reads 0.
- `load`=1, in any state:
  - `qout`←`qin`, counter←0, parity←^`qin`, state←SHIFT, `co`←0.
  - A load during SHIFT or PARITY aborts the current frame. No `co` is produced for the aborted frame.
- SHIFT, `enable`=1, `load`=0:
  - MSB_FIRST=1: `qout`←{`qout[WIDTH-2:0]`,`serialin`}.
  - MSB_FIRST=0: `qout`←{`serialin`,`qout[WIDTH-1:1]`}.
  - Counter increments by 1.
  - On the WIDTH-th shift: without parity, state←IDLE and `co`←1. With parity, state←PARITY.
- PARITY, `enable`=1, `load`=0: state←IDLE and `co`←1. `qout` is unchanged.
- `enable`=0, or state IDLE: `qout`, counter and state hold. `serialin` is ignored.
- `co` is 1 only in the cycle directly after the frame-ending edge. Otherwise it is 0.
- `serialout` is combinational:
  - In PARITY it is the parity register.
  - In every other state it is `qout[WIDTH-1]` (MSB_FIRST=1) or `qout[0]` (MSB_FIRST=0).
- `busy` = (state != IDLE).

## Timing
- Latency from load to first bit: 0. The first bit is valid on `serialout` in the cycle after the `load` edge.
- Bit i (0-based) is presented after i enabled edges following the load.
- Enable gaps stretch the frame but never drop or repeat a bit.
- `co` rises one cycle after the last data bit is shifted past, or after the parity bit's enabled edge.
- `busy` falls on that same edge.
- Simultaneous `load` and `enable`: load wins and no shift occurs.
- Reset asserted mid-frame: outputs clear immediately, independent of `clock`.
- Reset deassertion: the first active edge is the first rising `clock` edge with `reset`=1.

## Configuration
- `TRANSMITTER_PARITY_EN` defined: the PARITY state is compiled in.
  - Each frame is WIDTH+1 bits; the last bit is even parity (XOR of the loaded `qin`).
  - `co` follows the parity bit.
- Undefined: no PARITY state and no parity register.
  - Each frame is exactly WIDTH bits; `co` follows the WIDTH-th shift.

## Test plan
- WIDTH=8, MSB_FIRST=1, `reset` released, `load` `qin`=8'hB2, `enable`=1, `serialin`=1:
  - `serialout` reads 1,0,1,1,0,0,1,0.
  - `co` pulses once after the 8th enabled edge; then `qout`=8'hFF and `busy`=0.
- MSB_FIRST=0, `load` 8'h0B, `serialin`=0, continuous enable:
  - `serialout` reads 1,1,0,1,0,0,0,0.
  - Final `qout`=8'h00; single `co` pulse.
- 8'hB2 with `enable` toggling 1,0,1,0,…: same bit sequence as the first test, each bit held through disabled cycles; `co` after the 8th enabled edge only.
- Reload mid-frame: load 8'hB2, 3 shifts, then load 8'h0B:
  - No `co` for the first frame.
  - `qout`=8'h0B after the second load; the full 0B frame follows.
- `reset`=0 mid-shift between clock edges:
  - `qout`=0, `co`=0 and `busy`=0 immediately.
  - After release, outputs hold until the next `load`.
- With `TRANSMITTER_PARITY_EN`:
  - 8'hB2 produces a 9th bit of 0; 8'h0B produces a 9th bit of 1.
  - `busy` is high for 9 enabled edges; `co` follows the 9th.
